// File: rtl/csa_accum_ctrl_if.sv
// Handshake bundle for csa_accum_ctrl: operand input stream and resolved-result output.
interface csa_accum_ctrl_if #(
   parameter int WIDTH   = 4,
   parameter int MAX_OPS = 8
);
   localparam int OUT_W = WIDTH + $clog2(MAX_OPS);
   localparam int CNT_W = $clog2(MAX_OPS + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_result;
   logic [CNT_W-1:0] out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_result, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_result, out_count
   );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Multi-operand adder: carry-save accumulation of an operand stream, one carry-propagate add per packet.
// Optional abort input is enabled by defining CSA_ABORT_EN.
module csa_accum_ctrl #(
   parameter int WIDTH   = 4,
   parameter int MAX_OPS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef CSA_ABORT_EN
   input  logic             in_abort,
`endif
   csa_accum_ctrl_if.slave  bus
);
   localparam int OUT_W = WIDTH + $clog2(MAX_OPS);
   localparam int CNT_W = $clog2(MAX_OPS + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCUM   = 2'd1,
      S_RESOLVE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t           r_state;
   logic [OUT_W-1:0] r_sum;
   logic [OUT_W-1:0] r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic             r_out_valid;
   logic [OUT_W-1:0] r_out_result;
   logic [CNT_W-1:0] r_out_count;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_term;
   logic [OUT_W-1:0] w_d;
   logic [OUT_W-1:0] w_sum_nxt;
   logic [OUT_W-1:0] w_carry_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;

   function automatic logic [OUT_W-1:0] csa_sum(input logic [OUT_W-1:0] a,
                                                 input logic [OUT_W-1:0] b,
                                                 input logic [OUT_W-1:0] c);
      return a ^ b ^ c;
   endfunction

   // Majority bits move one place up; the top carry drops out (mod 2^OUT_W).
   function automatic logic [OUT_W-1:0] csa_carry(input logic [OUT_W-1:0] a,
                                                   input logic [OUT_W-1:0] b,
                                                   input logic [OUT_W-1:0] c);
      logic [OUT_W-1:0] maj;
      maj = (a & b) | (a & c) | (b & c);
      return {maj[OUT_W-2:0], 1'b0};
   endfunction

   assign w_in_ready     = rst_n && ((r_state == S_IDLE) || (r_state == S_ACCUM));
   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_result = r_out_result;
   assign bus.out_count  = r_out_count;

   // Next carry-save state for a beat presented this cycle.
   always_comb begin
      w_d         = {{(OUT_W-WIDTH){1'b0}}, bus.in_data};
      w_accept    = bus.in_valid && w_in_ready;
      w_sum_nxt   = csa_sum(r_sum, r_carry, w_d);
      w_carry_nxt = csa_carry(r_sum, r_carry, w_d);
      w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_accept && (bus.in_last || (w_cnt_nxt == MAX_CNT))) begin
         w_term = 1'b1;
      end else begin
         w_term = 1'b0;
      end
   end

   // Sequencing FSM with redundant accumulator and registered result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_sum        <= {OUT_W{1'b0}};
         r_carry      <= {OUT_W{1'b0}};
         r_cnt        <= {CNT_W{1'b0}};
         r_out_valid  <= 1'b0;
         r_out_result <= {OUT_W{1'b0}};
         r_out_count  <= {CNT_W{1'b0}};
      end else begin
`ifdef CSA_ABORT_EN
         // A finished result must still drain, so DONE is immune to abort.
         if (in_abort && (r_state != S_DONE)) begin
            r_state <= S_IDLE;
            r_sum   <= {OUT_W{1'b0}};
            r_carry <= {OUT_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
         end else begin
`else
         begin
`endif
            case (r_state)
               S_IDLE, S_ACCUM: begin
                  if (w_accept) begin
                     r_sum   <= w_sum_nxt;
                     r_carry <= w_carry_nxt;
                     r_cnt   <= w_cnt_nxt;
                     r_state <= w_term ? S_RESOLVE : S_ACCUM;
                  end
               end
               S_RESOLVE: begin
                  r_out_result <= r_sum + r_carry;
                  r_out_count  <= r_cnt;
                  r_out_valid  <= 1'b1;
                  r_state      <= S_DONE;
               end
               S_DONE: begin
                  if (bus.out_ready) begin
                     r_out_valid <= 1'b0;
                     r_sum       <= {OUT_W{1'b0}};
                     r_carry     <= {OUT_W{1'b0}};
                     r_cnt       <= {CNT_W{1'b0}};
                     r_state     <= S_IDLE;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end
endmodule
